// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder/subtractor sequencing a single full-adder cell
// Ports: clk, rst_n (async, active-low)
//   in_valid_i/in_ready_o, a_i, b_i, sub_i   operand handshake (sub_i: A + ~B + 1)
//   out_valid_o/out_ready_i                  result handshake
//   result_o, carry_out_o, overflow_o, zero_o  sum and flags, held outside DONE
//   busy_o                                   operation in RUN or DONE
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_out_o,
  output logic             overflow_o,
  output logic             zero_o,
  output logic             busy_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PEN = CW'(WIDTH - 2);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, result_q, result_d;
  logic carry_q, carry_d, cmsb_q, cmsb_d, co_q, co_d, ov_q, ov_d, z_q, z_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic fa_s, fa_co, c;
  fulladder u_fa (.a_i(a_q[0]), .b_i(b_q[0]), .c_i(carry_q), .s_o(fa_s), .c_o(fa_co));
  always_comb begin
    c = 1'b1;
    cnt_inc = cnt_q;
    for (int i = 0; i < CW; i++) begin
      cnt_inc[i] = cnt_q[i] ^ c;
      c = c & cnt_q[i];
    end
  end
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    carry_d = carry_q;
    cmsb_d = cmsb_q;
    cnt_d = cnt_q;
    result_d = result_q;
    co_d = co_q;
    ov_d = ov_q;
    z_d = z_q;
    if (state_q == IDLE && in_valid_i) begin
      state_d = RUN;
      a_d = a_i;
      b_d = sub_i ? ~b_i : b_i;
      carry_d = sub_i;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      res_d = {fa_s, res_q[WIDTH-1:1]};
      carry_d = fa_co;
      cnt_d = cnt_inc;
      cmsb_d = (cnt_q == PEN) ? fa_co : cmsb_q;
      if (cnt_q == LAST) begin
        state_d = DONE;
        result_d = res_d;
        co_d = fa_co;
        ov_d = cmsb_q ^ fa_co;
        z_d = ~|res_d;
      end
    end else if (state_q == DONE && out_ready_i) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      carry_q <= 1'b0;
      cmsb_q <= 1'b0;
      cnt_q <= '0;
      result_q <= '0;
      co_q <= 1'b0;
      ov_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      carry_q <= carry_d;
      cmsb_q <= cmsb_d;
      cnt_q <= cnt_d;
      result_q <= result_d;
      co_q <= co_d;
      ov_q <= ov_d;
      z_q <= z_d;
    end
  end
  assign in_ready_o = state_q == IDLE;
  assign out_valid_o = state_q == DONE;
  assign busy_o = state_q != IDLE;
  assign result_o = result_q;
  assign carry_out_o = co_q;
  assign overflow_o = ov_q;
  assign zero_o = z_q;
endmodule
